// File: rtl/bft_leaf_port_pkg.sv
// Shared packet layout and FSM encoding for the BFT leaf port.
package bft_leaf_port_pkg;

  localparam int unsigned PktW     = 49;
  localparam int unsigned ValidBit = 48;
  localparam int unsigned DestMsb  = 47;
  localparam int unsigned DestLsb  = 43;
  localparam int unsigned PortMsb  = 42;
  localparam int unsigned PortLsb  = 39;
  localparam int unsigned SeqMsb   = 38;
  localparam int unsigned SeqLsb   = 32;
  localparam int unsigned DataMsb  = 31;
  localparam int unsigned DataLsb  = 0;
  localparam int unsigned SeqW     = SeqMsb - SeqLsb + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StReplay
  } state_e;

  function automatic logic [PktW-1:0] pack_pkt(input logic [DestMsb-DestLsb:0] dest,
                                               input logic [PortMsb-PortLsb:0] port,
                                               input logic [SeqW-1:0]          seq,
                                               input logic [DataMsb-DataLsb:0] data);
    return {1'b1, dest, port, seq, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only together with a pop.
module sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 49
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(Depth);
  typedef logic [AW-1:0] idx_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t Full = cnt_t'(Depth);

  logic [Width-1:0] mem_q [Depth];
  idx_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t cnt_q, cnt_d;
  logic do_push, do_pop;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == Full);
    rdata_o = mem_q[rptr_q];
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = do_push ? wptr_q + idx_t'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + idx_t'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bft_leaf_port.sv
// Leaf-side port of a butterfly-fat-tree network: TX with replay buffer, RX with FIFO.
module bft_leaf_port
  import bft_leaf_port_pkg::*;
#(
  parameter int unsigned REPLAY_DEPTH = 8,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_req,
  output logic            ap_start,
  output logic [PktW-1:0] din_leaf_bft2interface,
  input  logic [PktW-1:0] dout_leaf_interface2bft,
  output logic            resend,
  input  logic            nack,
  input  logic            ack,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [4:0]      tx_dest,
  input  logic [3:0]      tx_port,
  input  logic [31:0]     tx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [PktW-1:0] rx_data
);

  localparam int unsigned AW = $clog2(REPLAY_DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [AW:0] ptr_t;
  localparam ptr_t Full = ptr_t'(REPLAY_DEPTH);

  state_e state_q, state_d;
  logic [PktW-2:0] rbuf_q [REPLAY_DEPTH];
  ptr_t head_q, head_d, tail_q, tail_d, rp_q, rp_d;
  ptr_t count, eff_rp;
  logic ap_start_q, ap_start_d;
  logic [SeqW-1:0] seq_q, seq_d;
  logic [PktW-1:0] din_q, din_d;
  logic resend_q, resend_d;
  logic tx_fire, ack_eff, emit;
  logic rx_in_valid, rx_pop, rx_full, rx_empty;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and replay pointer logic
  always_comb begin
    count   = tail_q - head_q;
    ack_eff = ack && (count != '0);
    tx_fire = tx_valid && tx_ready;
    head_d  = head_q + ptr_t'(ack_eff);
    tail_d  = tail_q + ptr_t'(tx_fire);
    // An ack that frees the entry about to be replayed pushes the replay past it.
    eff_rp  = (ack_eff && (rp_q == head_q)) ? head_d : rp_q;
    state_d = state_q;
    rp_d    = rp_q;
    emit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ap_start_q) state_d = StSend;
      end
      StSend: begin
        if (nack && (tail_d != head_d)) begin
          state_d = StReplay;
          rp_d    = head_d;
        end
      end
      StReplay: begin
        if (nack) begin
          rp_d = head_d;
          if (tail_q == head_d) state_d = StSend;
        end else if (eff_rp == tail_q) begin
          state_d = StSend;
        end else begin
          emit = 1'b1;
          rp_d = eff_rp + ptr_t'(1);
          if (rp_d == tail_q) state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    tx_ready               = (state_q == StSend) && (count != Full);
    ap_start               = ap_start_q;
    din_leaf_bft2interface = din_q;
    resend                 = resend_q;
    rx_valid               = !rx_empty;
  end

  // Datapath next-state
  always_comb begin
    ap_start_d = ap_start_q | start_req;
    seq_d      = seq_q;
    din_d      = '0;
    if (tx_fire) begin
      din_d = pack_pkt(tx_dest, tx_port, seq_q, tx_data);
      seq_d = seq_q + SeqW'(1);
    end else if (emit) begin
      din_d = {1'b1, rbuf_q[eff_rp[AW-1:0]]};
    end
    rx_in_valid = dout_leaf_interface2bft[ValidBit];
    rx_pop      = rx_valid && rx_ready;
    resend_d    = rx_in_valid && rx_full && !rx_pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      rp_q       <= '0;
      ap_start_q <= 1'b0;
      seq_q      <= '0;
      din_q      <= '0;
      resend_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      rp_q       <= rp_d;
      ap_start_q <= ap_start_d;
      seq_q      <= seq_d;
      din_q      <= din_d;
      resend_q   <= resend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_fire) begin
      rbuf_q[tail_q[AW-1:0]] <= din_d[PktW-2:0];
    end
  end

  sync_fifo #(
    .Depth(RX_DEPTH),
    .Width(PktW)
  ) u_rx_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (rx_in_valid),
    .wdata_i(dout_leaf_interface2bft),
    .pop_i  (rx_pop),
    .rdata_o(rx_data),
    .empty_o(rx_empty),
    .full_o (rx_full)
  );

endmodule
